// File: rtl/fp32_tap_reducer.sv
// Buffers a burst of NTAPS fp32 tap products and reduces them to one sum with a pairwise
// adder tree, time-multiplexed onto a single external pipelined fp32 adder.
module fp32_tap_reducer #(
  parameter int unsigned NTAPS   = 8,
  parameter int unsigned ADD_LAT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] prod_in,
  input  logic        prod_valid,
  output logic        prod_ready,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_op,
  output logic        add_vin,
  input  logic [31:0] add_res,
  input  logic        add_vout,
  output logic [31:0] sum_out,
  output logic        sum_valid,
  output logic        err
);

  localparam int unsigned AW = $clog2(NTAPS);
  localparam int unsigned DW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {StFill, StIssue, StWait, StDone} state_e;

  state_e        state_q, state_d;
  logic [31:0]   tap_q [NTAPS];
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] iss_cnt_q, iss_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] n_q, n_d;
  logic [31:0]   sum_out_q, sum_out_d;
  logic          err_q, err_d;
  logic [DW-1:0] drain_q, drain_d;

  logic          tap_we;
  logic [AW-1:0] tap_wa;
  logic [31:0]   tap_wd;
  logic [AW-1:0] idx_a, idx_b;
  logic          vout_ok;

  assign add_op    = 1'b0;
  assign sum_out   = sum_out_q;
  assign err       = err_q;
  assign idx_a     = iss_cnt_q << 1;
  assign idx_b     = idx_a | AW'(1);
  // Results still in flight from before a reset are ignored until the drain window expires.
  assign vout_ok   = add_vout && (drain_q == '0);

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    iss_cnt_d  = iss_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    n_d        = n_q;
    sum_out_d  = sum_out_q;
    err_d      = err_q;
    drain_d    = (drain_q != '0) ? drain_q - DW'(1) : drain_q;
    prod_ready = 1'b0;
    add_vin    = 1'b0;
    add_a      = '0;
    add_b      = '0;
    sum_valid  = 1'b0;
    tap_we     = 1'b0;
    tap_wa     = '0;
    tap_wd     = '0;

    if (vout_ok && (state_q != StWait || rd_cnt_q == n_q)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      StFill: begin
        prod_ready = 1'b1;
        if (prod_valid) begin
          tap_we = 1'b1;
          tap_wa = wr_cnt_q;
          tap_wd = prod_in;
          if (wr_cnt_q == AW'(NTAPS - 1)) begin
            wr_cnt_d  = '0;
            iss_cnt_d = '0;
            n_d       = AW'(NTAPS / 2);
            state_d   = StIssue;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end
      StIssue: begin
        add_vin = 1'b1;
        add_a   = tap_q[idx_a];
        add_b   = tap_q[idx_b];
        if (iss_cnt_q == n_q - AW'(1)) begin
          iss_cnt_d = '0;
          rd_cnt_d  = '0;
          state_d   = StWait;
        end else begin
          iss_cnt_d = iss_cnt_q + AW'(1);
        end
      end
      StWait: begin
        if (vout_ok && rd_cnt_q != n_q) begin
          tap_we = 1'b1;
          tap_wa = rd_cnt_q;
          tap_wd = add_res;
          if (rd_cnt_q == n_q - AW'(1)) begin
            rd_cnt_d = '0;
            if (n_q == AW'(1)) begin
              // Final result is the new tap 0; capture it now so it is valid alongside the strobe.
              sum_out_d = add_res;
              state_d   = StDone;
            end else begin
              n_d     = n_q >> 1;
              state_d = StIssue;
            end
          end else begin
            rd_cnt_d = rd_cnt_q + AW'(1);
          end
        end
      end
      StDone: begin
        sum_valid = 1'b1;
        wr_cnt_d  = '0;
        iss_cnt_d = '0;
        rd_cnt_d  = '0;
        state_d   = StFill;
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StFill;
      wr_cnt_q  <= '0;
      iss_cnt_q <= '0;
      rd_cnt_q  <= '0;
      n_q       <= '0;
      sum_out_q <= '0;
      err_q     <= 1'b0;
      drain_q   <= DW'(ADD_LAT);
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      iss_cnt_q <= iss_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      n_q       <= n_d;
      sum_out_q <= sum_out_d;
      err_q     <= err_d;
      drain_q   <= drain_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NTAPS; i++) begin
        tap_q[i] <= '0;
      end
    end else if (tap_we) begin
      tap_q[tap_wa] <= tap_wd;
    end
  end

endmodule

// File: tb/tb_fp32_tap_reducer.sv
// Directed bench for fp32_tap_reducer with a 4-stage behavioural fp32 adder alongside.
module tb_fp32_tap_reducer;

  localparam int unsigned NTAPS   = 8;
  localparam int unsigned ADD_LAT = 4;
  localparam int unsigned LAT     = NTAPS + $clog2(NTAPS) * ADD_LAT;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] prod_in;
  logic        prod_valid;
  logic        prod_ready;
  logic [31:0] add_a, add_b;
  logic        add_op;
  logic        add_vin;
  logic [31:0] add_res;
  logic        add_vout;
  logic [31:0] sum_out;
  logic        sum_valid;
  logic        err;

  always #5 clk = ~clk;

  fp32_tap_reducer #(.NTAPS(NTAPS), .ADD_LAT(ADD_LAT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .prod_in   (prod_in),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_op    (add_op),
    .add_vin   (add_vin),
    .add_res   (add_res),
    .add_vout  (add_vout),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .err       (err)
  );

  // Behavioural adder: exact for the values used here, not reset (in-flight results survive).
  function automatic real f2r(input logic [31:0] b);
    logic [10:0] e;
    logic [63:0] d;
    if (b[30:23] == 8'd0) return 0.0;
    e = 11'(b[30:23]) + 11'd896;
    d = {b[31], e, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  logic [3:0]  mv = 4'd0;
  logic [31:0] mr [4];
  logic        inj_v = 1'b0;
  logic [31:0] inj_r = 32'hDEADBEEF;

  always @(posedge clk) begin
    mv    <= {mv[2:0], add_vin};
    mr[0] <= r2f(f2r(add_a) + f2r(add_b));
    for (int i = 1; i < 4; i++) mr[i] <= mr[i-1];
  end

  assign add_vout = mv[3] | inj_v;
  assign add_res  = inj_v ? inj_r : mr[3];

  int cyc = 0;
  int vin_cnt = 0;
  int vin_base = 0;
  int last_acc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  bit gap = 1'b0;
  logic [31:0] feed_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (add_vin) vin_cnt <= vin_cnt + 1;
  end

  typedef struct {
    string       name;
    logic [31:0] p [8];
    bit          gap;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input int k);
    for (int i = 0; i < 8; i++) feed_q.push_back(vecs[k].p[i]);
  endtask

  task automatic push_ones();
    for (int i = 0; i < 8; i++) feed_q.push_back(32'h3F800000);
  endtask

  task automatic feed();
    int guard = 0;
    while (feed_q.size() > 0 && guard < 400) begin
      prod_in    = feed_q[0];
      prod_valid = 1'b1;
      if (prod_ready) begin
        last_acc = cyc;
        void'(feed_q.pop_front());
        step();
        if (gap) begin
          prod_valid = 1'b0;
          step();
        end
      end else begin
        step();
      end
      guard++;
    end
    prod_valid = 1'b0;
    check("feed_all_accepted", 32'(feed_q.size()), 32'd0);
    feed_q.delete();
  endtask

  task automatic expect_sum(input string name, input logic [31:0] exp, input logic exp_err,
                            input bit chk_ready);
    int guard = 0;
    int rdy_viol = 0;
    bit got = 1'b0;
    while (!got && guard < 200) begin
      if (sum_valid) begin
        got = 1'b1;
      end else begin
        if (chk_ready && prod_ready) rdy_viol++;
        step();
        guard++;
      end
    end
    check({name, "_seen"}, 32'(got), 32'd1);
    check({name, "_sum"}, sum_out, exp);
    check({name, "_latency"}, 32'(cyc - last_acc), 32'(LAT));
    check({name, "_vin_cycles"}, 32'(vin_cnt - vin_base), 32'(NTAPS - 1));
    check({name, "_err"}, 32'(err), 32'(exp_err));
    if (chk_ready) check({name, "_ready_low"}, 32'(rdy_viol), 32'd0);
    vin_base = vin_cnt;
    step();
    check({name, "_strobe_1cyc"}, 32'(sum_valid), 32'd0);
    check({name, "_sum_hold"}, sum_out, exp);
  endtask

  initial begin
    vecs[0].name = "ones";
    vecs[0].p    = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                     32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    vecs[0].gap  = 1'b0;
    vecs[0].exp  = 32'h41000000;
    vecs[1].name = "alt_sign";
    vecs[1].p    = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'hC0800000,
                     32'h40A00000, 32'hC0C00000, 32'h40E00000, 32'hC1000000};
    vecs[1].gap  = 1'b0;
    vecs[1].exp  = 32'hC0800000;
    vecs[2].name = "halves_gap";
    vecs[2].p    = '{32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000,
                     32'h40200000, 32'h40400000, 32'h40600000, 32'h40800000};
    vecs[2].gap  = 1'b1;
    vecs[2].exp  = 32'h41900000;
    vecs[3].name = "cancel_pi";
    vecs[3].p    = '{32'h40490FDB, 32'hC0490FDB, 32'h40490FDB, 32'hC0490FDB,
                     32'h40490FDB, 32'hC0490FDB, 32'h40490FDB, 32'hC0490FDB};
    vecs[3].gap  = 1'b0;
    vecs[3].exp  = 32'h00000000;

    rstn       = 1'b0;
    prod_valid = 1'b0;
    prod_in    = '0;
    step();
    step();
    check("rst_prod_ready", 32'(prod_ready), 32'd1);
    check("rst_add_vin", 32'(add_vin), 32'd0);
    check("rst_add_a", add_a, 32'd0);
    check("rst_add_b", add_b, 32'd0);
    check("rst_sum_out", sum_out, 32'd0);
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("add_op_zero", 32'(add_op), 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) step();

    for (int k = 0; k < 4; k++) begin
      gap = vecs[k].gap;
      push_vec(k);
      feed();
      expect_sum(vecs[k].name, vecs[k].exp, 1'b0, 1'b1);
    end
    gap = 1'b0;

    // Two bursts with prod_valid held high across the FILL re-entry.
    push_vec(0);
    push_vec(1);
    fork
      feed();
      begin
        expect_sum("b2b_first", vecs[0].exp, 1'b0, 1'b0);
        expect_sum("b2b_second", vecs[1].exp, 1'b0, 1'b0);
      end
    join

    // Reset in the first cycle after the level-1 issues complete.
    push_ones();
    feed();
    for (int i = 0; i < 4; i++) step();
    check("pre_rst_vin_done", 32'(add_vin), 32'd0);
    rstn = 1'b0;
    step();
    check("in_rst_ready", 32'(prod_ready), 32'd1);
    step();
    rstn = 1'b1;
    begin
      int sv_seen = 0;
      int err_seen = 0;
      for (int i = 0; i < 30; i++) begin
        if (sum_valid) sv_seen++;
        if (err) err_seen++;
        step();
      end
      check("rst_no_sum_valid", 32'(sv_seen), 32'd0);
      check("rst_drain_no_err", 32'(err_seen), 32'd0);
    end
    vin_base = vin_cnt;
    push_ones();
    feed();
    expect_sum("post_rst", 32'h41000000, 1'b0, 1'b1);

    // Spurious add_vout in the middle of FILL.
    for (int i = 0; i < 3; i++) feed_q.push_back(vecs[1].p[i]);
    feed();
    inj_v = 1'b1;
    step();
    inj_v = 1'b0;
    check("inj_err_set", 32'(err), 32'd1);
    for (int i = 3; i < 8; i++) feed_q.push_back(vecs[1].p[i]);
    feed();
    expect_sum("post_inj", vecs[1].exp, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step();
    check("err_sticky", 32'(err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
